ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scanner fed by a sequential double-dabble BCD converter.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 13,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] Anode,
    output logic [6:0]        LED_out
);

    // One spare BCD digit above the display width always exists, so the
    // overflow test is a plain OR over the surplus digits.
    localparam int MIN_BD = (DATA_W + 2) / 3;
    localparam int BD     = ((MIN_BD > DIGITS) ? MIN_BD : DIGITS) + 1;
    localparam int BW     = BD * 4;
    localparam int DW     = DIGITS * 4;
    localparam int CW     = $clog2(DATA_W);
    localparam int RW     = $clog2(REFRESH_DIV);
    localparam int IW     = $clog2(DIGITS);

    localparam logic [6:0] SEG_ZERO = 7'b0000001;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
`ifdef SSD_LZB_EN
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`endif

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] bin_q;
    logic [DATA_W-1:0] bin_d;
    logic [BW-1:0]     work_q;
    logic [BW-1:0]     work_d;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     shifted;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [DW-1:0]     disp_q;
    logic [DW-1:0]     disp_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [RW-1:0]     rcnt_q;
    logic [RW-1:0]     rcnt_d;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idx_d;
    logic [DIGITS-1:0] anode_d;
    logic [3:0]        digit;
    logic [6:0]        seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to every digit >= 5, then shift in a bit.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < BD; i++) begin
            if (work_q[i*4 +: 4] > 4'd4) begin
                adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted = BW'({adj, bin_q[DATA_W-1]});
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CONVERT;
                    bin_d   = value;
                    work_d  = '0;
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                bin_d  = bin_q << 1;
                work_d = shifted;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) begin
                    state_d = IDLE;
                    disp_d  = shifted[DW-1:0];
                    ovf_d   = |shifted[BW-1:DW];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Segments are decoded from next-cycle index and display so that anode,
    // digit and result all switch together on one edge.
    always_comb begin
        rcnt_d = rcnt_q + RW'(1);
        idx_d  = idx_q;
        if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        anode_d = ~(DIGITS'(1) << idx_d);
        digit   = disp_d[idx_d*4 +: 4];
    end

`ifdef SSD_LZB_EN
    logic [DIGITS-1:0] blank;
    logic              lz_run;

    always_comb begin
        blank  = '0;
        lz_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run   = lz_run && (disp_d[i*4 +: 4] == 4'd0);
            blank[i] = lz_run && !ovf_d;
        end
    end
`endif

    always_comb begin
        seg_d = seg7(digit);
`ifdef SSD_LZB_EN
        if (blank[idx_d]) begin
            seg_d = SEG_BLANK;
        end
`endif
        if (ovf_d) begin
            seg_d = SEG_DASH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            rcnt_q  <= '0;
            idx_q   <= '0;
            Anode   <= ~DIGITS'(1);
            LED_out <= SEG_ZERO;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            Anode   <= anode_d;
            LED_out <= seg_d;
        end
    end

    assign busy = (state_q == CONVERT);
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl: vector table, hand-written corner sequences,
// and random loads checked against an arithmetic decimal display model.
module tb_ssd_scan_ctrl;

    localparam logic [6:0] S0  = 7'b0000001;
    localparam logic [6:0] S1  = 7'b1001111;
    localparam logic [6:0] S2  = 7'b0010010;
    localparam logic [6:0] S3  = 7'b0000110;
    localparam logic [6:0] S4  = 7'b1001100;
    localparam logic [6:0] S5  = 7'b0100100;
    localparam logic [6:0] S6  = 7'b0100000;
    localparam logic [6:0] S7  = 7'b0001111;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] S9  = 7'b0000100;
    localparam logic [6:0] DSH = 7'b1111110;
`ifdef SSD_LZB_EN
    localparam logic [6:0] BLK = 7'b1111111;
`else
    localparam logic [6:0] BLK = 7'b0000001;
`endif
    localparam logic [27:0] ZERO = {BLK, BLK, BLK, S0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] value1 = '0;
    logic [13:0] value2 = '0;
    logic        load1 = 1'b0;
    logic        load2 = 1'b0;
    logic        busy1, busy2, ovf1, ovf2;
    logic [3:0]  an1, an2;
    logic [6:0]  led1, led2;

    bit          sel = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    logic [27:0] prev1 = '0;
    logic [27:0] prev2 = '0;

    logic        busy_s, ovf_s;
    logic [3:0]  an_s;
    logic [6:0]  led_s;

    assign busy_s = sel ? busy2 : busy1;
    assign ovf_s  = sel ? ovf2 : ovf1;
    assign an_s   = sel ? an2 : an1;
    assign led_s  = sel ? led2 : led1;

    // 13-bit instance cannot hold values above 8191, so a 14-bit instance
    // covers the overflow cases.
    ssd_scan_ctrl #(.DIGITS(4), .DATA_W(13), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .value(value1), .load(load1),
        .busy(busy1), .ovf(ovf1), .Anode(an1), .LED_out(led1)
    );

    ssd_scan_ctrl #(.DIGITS(4), .DATA_W(14), .REFRESH_DIV(4)) dut_w (
        .clk(clk), .rst(rst), .value(value2), .load(load2),
        .busy(busy2), .ovf(ovf2), .Anode(an2), .LED_out(led2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    typedef struct {
        string       name;
        int unsigned v;
        bit          wide;
        int          inj;
        logic        exp_ovf;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] digit_seg(int unsigned d);
        case (d)
            0: return S0;
            1: return S1;
            2: return S2;
            3: return S3;
            4: return S4;
            5: return S5;
            6: return S6;
            7: return S7;
            8: return S8;
            default: return S9;
        endcase
    endfunction

    function automatic logic [27:0] model_segs(int unsigned v);
        logic [27:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999) r[i*7 +: 7] = DSH;
`ifdef SSD_LZB_EN
            else if (i > 0 && v < p) r[i*7 +: 7] = 7'b1111111;
`endif
            else r[i*7 +: 7] = digit_seg((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_load(int unsigned v);
        @(negedge clk);
        if (sel) begin
            value2 = 14'(v);
            load2  = 1'b1;
        end else begin
            value1 = 13'(v);
            load1  = 1'b1;
        end
        @(posedge clk);
        #1;
        load1 = 1'b0;
        load2 = 1'b0;
    endtask

    task automatic wait_done(string tag, int exp_len, logic [27:0] hold, int inj);
        int n;
        int id;
        n = 0;
        @(negedge clk);
        while (busy_s && n < 60) begin
            id = (cyc / 4) % 4;
            chk({tag, "_hold"}, 32'(led_s), 32'(hold[id*7 +: 7]));
            if (n == inj) begin
                value1 = 13'd99;
                value2 = 14'd99;
                if (sel) load2 = 1'b1;
                else load1 = 1'b1;
            end else begin
                load1 = 1'b0;
                load2 = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        load1 = 1'b0;
        load2 = 1'b0;
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
    endtask

    task automatic scan_check(string tag, logic [27:0] exp);
        int id;
        logic [3:0] ea;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            id = (cyc / 4) % 4;
            ea = ~(4'b0001 << id);
            chk({tag, "_an"}, 32'(an_s), 32'(ea));
            chk({tag, "_seg"}, 32'(led_s), 32'(exp[id*7 +: 7]));
        end
    endtask

    task automatic run_vec(string tag, int unsigned v, bit wide, int inj,
                           logic exp_ovf, logic [27:0] segs);
        sel = wide;
        do_load(v);
        wait_done({tag, "_busy"}, wide ? 14 : 13, wide ? prev2 : prev1, inj);
        chk({tag, "_ovf"}, 32'(ovf_s), 32'(exp_ovf));
        scan_check(tag, segs);
        chk({tag, "_idle"}, 32'(busy_s), 32'(0));
        if (wide) prev2 = segs;
        else prev1 = segs;
    endtask

    initial begin
        bit          w;
        int unsigned v;
        int          inj;

        vecs.push_back('{"v1234", 1234, 1'b0, -1, 1'b0, {S1, S2, S3, S4}});
        vecs.push_back('{"v7", 7, 1'b0, -1, 1'b0, {BLK, BLK, BLK, S7}});
        vecs.push_back('{"v42_ign", 42, 1'b0, 2, 1'b0, {BLK, BLK, S4, S2}});
        vecs.push_back('{"v0", 0, 1'b0, -1, 1'b0, {BLK, BLK, BLK, S0}});
        vecs.push_back('{"v8191", 8191, 1'b0, -1, 1'b0, {S8, S1, S9, S1}});
        vecs.push_back('{"v1050", 1050, 1'b0, -1, 1'b0, {S1, S0, S5, S0}});
        vecs.push_back('{"v6083", 6083, 1'b0, 5, 1'b0, {S6, S0, S8, S3}});
        vecs.push_back('{"w12000", 12000, 1'b1, -1, 1'b1, {DSH, DSH, DSH, DSH}});
        vecs.push_back('{"w5", 5, 1'b1, -1, 1'b0, {BLK, BLK, BLK, S5}});
        vecs.push_back('{"w9999", 9999, 1'b1, -1, 1'b0, {S9, S9, S9, S9}});
        vecs.push_back('{"w10000", 10000, 1'b1, -1, 1'b1, {DSH, DSH, DSH, DSH}});
        vecs.push_back('{"w16383", 16383, 1'b1, -1, 1'b1, {DSH, DSH, DSH, DSH}});

        #1 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy1), 32'(0));
        chk("rst_ovf", 32'(ovf1), 32'(0));
        chk("rst_an", 32'(an1), 32'(4'b1110));
        chk("rst_led", 32'(led1), 32'(S0));
        chk("rst_an_w", 32'(an2), 32'(4'b1110));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sel = 1'b0;
        scan_check("scan_reset", ZERO);
        prev1 = ZERO;
        prev2 = ZERO;

        foreach (vecs[k]) begin
            run_vec(vecs[k].name, vecs[k].v, vecs[k].wide, vecs[k].inj,
                    vecs[k].exp_ovf, vecs[k].segs);
        end

        // abort a conversion with reset, then load on the first edge after release
        sel = 1'b0;
        do_load(8191);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy1), 32'(0));
        chk("mid_rst_an", 32'(an1), 32'(4'b1110));
        chk("mid_rst_led", 32'(led1), 32'(S0));
        chk("mid_rst_ovf_w", 32'(ovf2), 32'(0));
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        value1 = 13'd1234;
        load1  = 1'b1;
        @(posedge clk);
        #1;
        load1 = 1'b0;
        chk("first_load", 32'(busy1), 32'(1));
        prev1 = ZERO;
        prev2 = ZERO;
        wait_done("after_rst_busy", 13, ZERO, -1);
        chk("after_rst_ovf", 32'(ovf1), 32'(0));
        scan_check("after_rst", {S1, S2, S3, S4});
        prev1 = {S1, S2, S3, S4};

        for (int r = 0; r < 14; r++) begin
            w   = 1'($urandom_range(0, 1));
            v   = w ? $urandom_range(0, 16383) : $urandom_range(0, 8191);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            run_vec($sformatf("rnd%0d", r), v, w, inj, v > 9999, model_segs(v));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
